// File: rtl/anita3_event_writer_if.sv
// anita3_event_writer_if: event word stream in and event buffer write port out
interface anita3_event_writer_if;
    logic [15:0] evt_dat_i;
    logic        evt_valid_i;
    logic        evt_last_i;
    logic        evt_ready_o;
    logic [7:0]  event_wr_addr_o;
    logic [15:0] event_wr_dat_o;
    logic        event_wr_o;

    modport slave (
        input  evt_dat_i, evt_valid_i, evt_last_i,
        output evt_ready_o, event_wr_addr_o, event_wr_dat_o, event_wr_o
    );

    modport master (
        output evt_dat_i, evt_valid_i, evt_last_i,
        input  evt_ready_o, event_wr_addr_o, event_wr_dat_o, event_wr_o
    );
endinterface

// File: rtl/anita3_event_writer.sv
// anita3_event_writer: writes each event as exactly 64 words into alternating buffers
module anita3_event_writer (
    input  logic                         clk33_i,
    input  logic                         rst_n_i,
    anita3_event_writer_if.slave         evt_if,
    input  logic [1:0]                   buffer_active_i,
    input  logic                         clear_evt_i,
    output logic                         event_done_o,
    output logic [15:0]                  event_count_o,
    output logic                         truncated_o
);
    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_PAD, S_DROP, S_DONE} state_t;

    state_t      r_state, w_state_nxt;
    logic        r_wr_buf;
    logic        r_clr_d;
    logic [5:0]  r_idx;
    logic [15:0] r_count;
    logic        r_trunc;
    logic        w_last_idx;
    logic        w_trunc;

    assign w_last_idx             = (r_idx == 6'd63);
    assign w_trunc                = (r_state == S_WRITE) && evt_if.evt_valid_i && !evt_if.evt_last_i && w_last_idx;
    assign evt_if.event_wr_addr_o = {1'b0, r_wr_buf, r_idx};
    assign event_count_o          = r_count;
    assign truncated_o            = r_trunc;

    // State register
    always_ff @(posedge clk33_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next state and write-port/handshake outputs; in WRITE the data passes straight through
    always_comb begin
        w_state_nxt           = r_state;
        evt_if.evt_ready_o    = 1'b0;
        evt_if.event_wr_o     = 1'b0;
        evt_if.event_wr_dat_o = 16'h0000;
        event_done_o          = 1'b0;
        case (r_state)
            S_IDLE: w_state_nxt = buffer_active_i[r_wr_buf] ? S_IDLE : S_WRITE;
            S_WRITE: begin
                evt_if.evt_ready_o    = 1'b1;
                evt_if.event_wr_o     = evt_if.evt_valid_i;
                evt_if.event_wr_dat_o = evt_if.evt_valid_i ? evt_if.evt_dat_i : 16'h0000;
                if (evt_if.evt_valid_i)
                    w_state_nxt = evt_if.evt_last_i ? (w_last_idx ? S_DONE : S_PAD)
                                                    : (w_last_idx ? S_DROP : S_WRITE);
            end
            S_PAD: begin
                evt_if.event_wr_o = 1'b1;
                w_state_nxt       = w_last_idx ? S_DONE : S_PAD;
            end
            S_DROP: begin
                evt_if.evt_ready_o = 1'b1;
                w_state_nxt        = (evt_if.evt_valid_i && evt_if.evt_last_i) ? S_DONE : S_DROP;
            end
            S_DONE: begin
                // A clear seen last cycle pushes the pulse out so it never lines up with the manager's clear
                event_done_o = !r_clr_d;
                w_state_nxt  = r_clr_d ? S_DONE : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Word index, buffer select, event counter, sticky truncation flag and delayed clear
    always_ff @(posedge clk33_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wr_buf <= 1'b0;
            r_clr_d  <= 1'b0;
            r_idx    <= 6'd0;
            r_count  <= 16'h0000;
            r_trunc  <= 1'b0;
        end else begin
            r_clr_d <= clear_evt_i;
            if (event_done_o) begin
                r_wr_buf <= ~r_wr_buf;
                r_idx    <= 6'd0;
                r_count  <= r_count + 16'h0001;
            end else if (evt_if.event_wr_o) begin
                r_idx <= r_idx + 6'd1;
            end
            if (w_trunc) r_trunc <= 1'b1;
        end
    end
endmodule

// File: tb/tb_anita3_event_writer.sv
// tb_anita3_event_writer: directed scoreboard bench for the event writer
module tb_anita3_event_writer;
    logic        clk33_i = 1'b0;
    logic        rst_n_i = 1'b1;
    logic [1:0]  buffer_active_i = 2'b00;
    logic        clear_evt_i = 1'b0;
    logic        event_done_o;
    logic [15:0] event_count_o;
    logic        truncated_o;

    anita3_event_writer_if evt_if();

    anita3_event_writer dut (
        .clk33_i         (clk33_i),
        .rst_n_i         (rst_n_i),
        .evt_if          (evt_if),
        .buffer_active_i (buffer_active_i),
        .clear_evt_i     (clear_evt_i),
        .event_done_o    (event_done_o),
        .event_count_o   (event_count_o),
        .truncated_o     (truncated_o)
    );

    always #5 clk33_i = ~clk33_i;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_done = 0;
    bit          s_acc;
    bit          s_ready;
    logic        exp_buf = 1'b0;
    logic [23:0] q_wr[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample and score DUT outputs at the falling edge, return just after the rising edge
    task automatic step();
        logic [23:0] e;
        @(negedge clk33_i);
        s_ready = evt_if.evt_ready_o;
        s_acc   = evt_if.evt_valid_i && evt_if.evt_ready_o;
        if (evt_if.event_wr_o) begin
            chk("write_expected", 32'(q_wr.size() != 0), 32'd1);
            if (q_wr.size() != 0) begin
                e = q_wr.pop_front();
                chk("wr_addr", 32'(evt_if.event_wr_addr_o), 32'(e[23:16]));
                chk("wr_dat", 32'(evt_if.event_wr_dat_o), 32'(e[15:0]));
            end
        end
        if (event_done_o) begin
            n_done++;
            chk("done_vs_wr", 32'(evt_if.event_wr_o), 32'd0);
            chk("all_writes_before_done", 32'(q_wr.size()), 32'd0);
        end
        @(posedge clk33_i);
        #1;
    endtask

    task automatic drive_word(input logic [15:0] d, input bit last, input bit clr);
        int k;
        evt_if.evt_dat_i   = d;
        evt_if.evt_valid_i = 1'b1;
        evt_if.evt_last_i  = last;
        clear_evt_i        = clr;
        k = 0;
        do begin
            step();
            k++;
        end while (!s_acc && k < 100);
        chk("accept", 32'(s_acc), 32'd1);
        evt_if.evt_valid_i = 1'b0;
        evt_if.evt_last_i  = 1'b0;
        clear_evt_i        = 1'b0;
    endtask

    task automatic send_event(input int n, input logic [15:0] base, input bit clr_last, output int lat);
        int d0;
        for (int i = 0; i < 64; i++)
            q_wr.push_back({1'b0, exp_buf, 6'(i), (i < n) ? base + 16'(i) : 16'h0000});
        for (int i = 0; i < n; i++)
            drive_word(base + 16'(i), i == n - 1, clr_last && (i == n - 1));
        d0  = n_done;
        lat = 0;
        while (n_done == d0 && lat < 300) begin
            step();
            lat++;
        end
        chk("done_seen", 32'(n_done - d0), 32'd1);
        repeat (3) step();
        chk("single_done", 32'(n_done - d0), 32'd1);
        exp_buf = ~exp_buf;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_ready", 32'(evt_if.evt_ready_o), 32'd0);
        chk("rst_wr", 32'(evt_if.event_wr_o), 32'd0);
        chk("rst_done", 32'(event_done_o), 32'd0);
        chk("rst_addr", 32'(evt_if.event_wr_addr_o), 32'h00);
        chk("rst_dat", 32'(evt_if.event_wr_dat_o), 32'h0000);
        chk("rst_count", 32'(event_count_o), 32'h0000);
        chk("rst_trunc", 32'(truncated_o), 32'd0);
    endtask

    initial begin
        int lat;
        int d0;
        bit any_ready;
        evt_if.evt_dat_i   = 16'h0000;
        evt_if.evt_valid_i = 1'b0;
        evt_if.evt_last_i  = 1'b0;
        #1 rst_n_i = 1'b0;
        #1 chk_reset_outputs();
        repeat (2) @(posedge clk33_i);
        #1 rst_n_i = 1'b1;

        // Full 64-word event into buffer 0, done one cycle after the last word
        send_event(64, 16'h0000, 1'b0, lat);
        chk("e1_done_latency", 32'(lat), 32'd1);
        chk("e1_count", 32'(event_count_o), 32'd1);
        chk("e1_trunc", 32'(truncated_o), 32'd0);

        // Short event lands in buffer 1 and is zero padded to index 63
        send_event(3, 16'hA001, 1'b0, lat);
        chk("e2_count", 32'(event_count_o), 32'd2);
        chk("e2_trunc", 32'(truncated_o), 32'd0);

        // Oversized event: 64 written, 6 swallowed, truncation flagged
        send_event(70, 16'h7000, 1'b0, lat);
        chk("e3_count", 32'(event_count_o), 32'd3);
        chk("e3_trunc", 32'(truncated_o), 32'd1);

        // Buffer 0 busy for the following event; clear strobe alongside the last word delays done
        buffer_active_i = 2'b01;
        send_event(64, 16'h4000, 1'b1, lat);
        chk("e4_clear_latency", 32'(lat), 32'd2);
        chk("e4_count", 32'(event_count_o), 32'd4);

        // Writer must sit in IDLE while buffer 0 is occupied, then start one cycle after it frees
        any_ready = 1'b0;
        repeat (5) begin
            step();
            any_ready |= s_ready;
        end
        chk("blocked_ready", 32'(any_ready), 32'd0);
        buffer_active_i = 2'b00;
        step();
        chk("unblock_ready_idle", 32'(s_ready), 32'd0);
        step();
        chk("unblock_ready_write", 32'(s_ready), 32'd1);
        send_event(4, 16'hB000, 1'b0, lat);
        chk("e5_count", 32'(event_count_o), 32'd5);
        chk("e5_trunc_sticky", 32'(truncated_o), 32'd1);

        // Reset after 10 words of an event in buffer 1
        for (int i = 0; i < 10; i++) begin
            q_wr.push_back({1'b0, exp_buf, 6'(i), 16'h5000 + 16'(i)});
            drive_word(16'h5000 + 16'(i), 1'b0, 1'b0);
        end
        #2 rst_n_i = 1'b0;
        #1 chk_reset_outputs();
        q_wr.delete();
        exp_buf = 1'b0;
        d0 = n_done;
        repeat (2) step();
        rst_n_i = 1'b1;
        repeat (2) step();
        chk("no_done_on_reset", 32'(n_done - d0), 32'd0);

        // Next event restarts at buffer 0, index 0
        send_event(3, 16'hC001, 1'b0, lat);
        chk("e7_count", 32'(event_count_o), 32'd1);
        chk("e7_trunc", 32'(truncated_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/anita3_event_writer.md
ANITA3_EVENT_WRITER -- requirements
Module: anita3_event_writer

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning):
REQ-002 clk33_i  in  1  sole clock, 33 MHz domain; all logic on rising edge.
REQ-003 rst_n_i  in  1  asynchronous, active-low reset.
REQ-004 evt_dat_i  in  16  incoming event data word.
REQ-005 evt_valid_i  in  1  word valid.
REQ-006 evt_last_i  in  1  marks the final word of the event; qualified by evt_valid_i.
REQ-007 evt_ready_o  out  1  word accepted when evt_valid_i && evt_ready_o.
REQ-008 buffer_active_i  in  2  per-buffer occupied flags from the dual event buffer manager.
REQ-009 clear_evt_i  in  1  the same raw clear strobe delivered to the buffer manager.
REQ-010 event_wr_addr_o  out  8  {1'b0, wr_buf, word_idx[5:0]}.
REQ-011 event_wr_dat_o  out  16  write data.
REQ-012 event_wr_o  out  1  write enable, one word per asserted cycle.
REQ-013 event_done_o  out  1  single-cycle event-complete pulse.
REQ-014 event_count_o  out  16  completed events, wraps 0xFFFF->0x0000.
REQ-015 truncated_o  out  1  sticky: some event exceeded 64 words.

Function
REQ-016 The block SHALL implement states IDLE, WRITE, PAD, DROP, DONE.
REQ-017 The block SHALL hold a 1-bit wr_buf register selecting the target buffer; event_wr_addr_o[6] SHALL equal wr_buf in every state.
REQ-018 IDLE: evt_ready_o=0; the block SHALL go to WRITE on the first cycle buffer_active_i[wr_buf]==0, and SHALL wait while it is 1.
REQ-019 WRITE: evt_ready_o=1; each accepted word SHALL drive event_wr_o=1, event_wr_dat_o=evt_dat_i, address word_idx in the same cycle (combinational pass-through, zero latency), then word_idx increments.
REQ-020 An accepted word with evt_last_i=1 and word_idx<63 SHALL move to PAD; with word_idx==63 it SHALL move directly to DONE.
REQ-021 An accepted word at word_idx==63 with evt_last_i=0 SHALL move to DROP and set truncated_o.
REQ-022 PAD: evt_ready_o=0; one zero word per cycle at word_idx+1..63 with event_wr_o=1; after writing index 63 go to DONE.
REQ-023 DROP: evt_ready_o=1; accepted words SHALL be discarded (event_wr_o=0) until an accepted word has evt_last_i=1, then go to DONE.
REQ-024 DONE: event_done_o SHALL pulse for exactly one cycle, then wr_buf toggles, word_idx clears to 0, event_count_o increments, state returns to IDLE.
REQ-025 The block SHALL register clear_evt_i into clr_d; in DONE, if clr_d==1 the pulse SHALL be deferred one cycle (state stays DONE), so done never coincides with the manager's internal clear strobe.
REQ-026 event_done_o SHALL never assert in the same cycle as event_wr_o.
REQ-027 Every event SHALL write exactly 64 words (indices 0..63) before event_done_o.
REQ-028 buffer_active_i SHALL be sampled only in IDLE; changes in other states have no effect.
REQ-029 A 0->1 change of clear_evt_i outside DONE SHALL have no effect other than updating clr_d.

Reset
REQ-030 While rst_n_i=0, the block SHALL immediately force: state=IDLE, wr_buf=0, word_idx=0, clr_d=0, event_count_o=0, truncated_o=0, evt_ready_o=0, event_wr_o=0, event_done_o=0, event_wr_addr_o=0x00, event_wr_dat_o=0x0000.
REQ-031 Reset asserted mid-event SHALL abandon the event with no done pulse; after release the next event targets buffer 0 at index 0.
REQ-032 truncated_o SHALL clear only on reset.

Verification
REQ-033 Buffers free, 64 words 0x0000..0x003F, last on the 64th -> writes to addr 0x00..0x3F, one done pulse, next event at 0x40..0x7F, event_count_o=1.
REQ-034 3-word event 0xA001,0xA002,0xA003 (last) -> writes at 0x00..0x02, zeros at 0x03..0x3F, done after address 0x3F, truncated_o=0.
REQ-035 70-word event -> 64 words at 0x00..0x3F, 6 words discarded with ready=1, truncated_o=1, single done.
REQ-036 buffer_active_i=2'b01 with wr_buf=0 -> evt_ready_o stays 0; drop to 2'b00 -> WRITE on the next cycle.
REQ-037 clear_evt_i=1 on the cycle before DONE entry -> done pulse delayed exactly one cycle, still single pulse.
REQ-038 rst_n_i low after 10 words -> all outputs 0 asynchronously, no done; next event writes from 0x00.
